fb_scanout_arbiter: RTL and testbench
=====================================

Name: fb_scanout_arbiter

Overview:
- Owns the single-port, double-buffered framebuffer RAM and shares it between two requesters: display line prefetch (read, deadline-critical) and renderer pixel writes (valid/ready).
- Copies one requested framebuffer line into the display line buffer, reserving bounded write slots so the renderer always makes progress.
- Performs the front/back buffer swap only at frame start.
- Sits in the pixel clock domain between the VGA timing/paint logic and the framebuffer memory.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- PIX_W, 12, pixel width (RGB444).
- ADDR_W, 19, per-bank address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES.
- BURST, 16, consecutive line reads between renderer write slots.

Ports:
- pixel_clk  in  1  pixel clock
- pixel_clk_rstn  in  1  asynchronous active-low reset
- line_req  in  1  one-cycle pulse: prefetch line line_y
- line_y  in  10  line to fetch
- line_busy  out  1  prefetch in progress
- line_done  out  1  one-cycle pulse with the final line-buffer write
- overrun  out  1  one-cycle pulse: line_req dropped because busy
- lb_wr_en  out  1  line buffer write enable
- lb_wr_addr  out  10  line buffer x index
- lb_wr_data  out  PIX_W  line buffer data
- wr_valid  in  1  renderer write request
- wr_ready  out  1  renderer write accepted this cycle
- wr_x  in  10  pixel x
- wr_y  in  10  pixel y
- wr_data  in  PIX_W  pixel value
- swap_req  in  1  one-cycle pulse: back buffer complete
- frame_start  in  1  one-cycle pulse at start of vsync
- swap_pending  out  1  swap requested, not yet executed
- front_sel  out  1  bank currently scanned out
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W+1  {bank, y*H_RES+x}
- mem_wdata  out  PIX_W  RAM write data
- mem_rdata  in  PIX_W  RAM read data, valid one cycle after the read issue

Behaviour:
- Reset (asynchronous, any time): state IDLE; all outputs 0; front_sel=0; swap_pending=0; counters cleared. An in-flight line is abandoned with no line_done.
- mem_* are combinational from state/counters and wr_*. lb_wr_en/lb_wr_addr are registered; lb_wr_data = mem_rdata.
- wr_ready depends only on state, slot counter and swap_pending, never on wr_valid.
- FSM IDLE:
  - line_req with line_y<V_RES → LOAD.
  - line_req with line_y≥V_RES is ignored.
  - wr_ready = !swap_pending.
- FSM LOAD (1 cycle):
  - Register base = line_y*H_RES and bank = front_sel.
  - x=0, slot_cnt=0, line_busy=1.
  - wr_ready=0.
  - → READ.
- FSM READ:
  - Normal cycle: issue read at {bank, base+x}, x++, slot_cnt++.
  - Slot cycle: when slot_cnt==BURST and x<H_RES, the cycle is a write slot. No read is issued; slot_cnt=0; wr_ready = !swap_pending.
  - A slot cycle is consumed even when wr_valid=0, so timing is deterministic.
  - After read x=H_RES-1 is issued → DRAIN.
- FSM DRAIN (1 cycle): final lb_wr_en; line_done=1; → IDLE.
- Line timing (H_RES=640, BURST=16):
  - Line needs 640 reads + 39 slots = 679 READ cycles.
  - line_req at cycle 0 → LOAD c1 → READ c2..c680 → DRAIN c681 → IDLE c682. Fits the 800-cycle line.
- lb_wr_en is asserted the cycle after each read issue, with lb_wr_addr = that read's x.
- Write handshake: transfer when wr_valid && wr_ready.
  - Transfer issues mem_en=1, mem_we=1, addr {~front_sel, wr_y*H_RES+wr_x} (combinational constant multiply), mem_wdata=wr_data.
  - wr_x≥H_RES or wr_y≥V_RES: handshake completes, no memory access (mem_en=0).
- line_req while line_busy: ignored, overrun pulses; the current line is unaffected.
- Swap:
  - swap_req sets swap_pending.
  - A later frame_start with swap_pending set toggles front_sel and clears swap_pending.
  - swap_req and frame_start in the same cycle: pending is set, swap waits for the next frame_start.
  - A swap during READ does not change the latched bank of the line in progress.
  - While swap_pending, wr_ready=0 (renderer stalls until the swap).

Decomposition:
- Shared package fb_pkg: fb_state_t enum (IDLE, LOAD, READ, DRAIN); constants FB_H_RES, FB_V_RES, FB_PIX_W, FB_ADDR_W.
- Optional sub-module fb_swap_ctrl: swap_pending/front_sel logic, about 30 lines.

Test Plan:
- Reset, then line_req with line_y=3: mem_addr reads {0,1920..2559}; line_done at cycle 681; lb_wr_addr 0..639 in order with data matching the RAM model.
- wr_valid held high during the line-3 fetch: exactly 39 writes are accepted, each in the cycle after every 16th read. Writes target bank 1. The fetch completes on time.
- Write in IDLE with wr_x=5, wr_y=2, data 0xABC: mem_addr={1,1285}, mem_we=1. Write with wr_x=700: wr_ready handshake completes, mem_en=0.
- swap_req, then frame_start 10 cycles later: swap_pending high for 10 cycles with wr_ready=0; front_sel 0→1; subsequent writes target bank 0.
- swap_req and frame_start in the same cycle: front_sel unchanged; it toggles at the next frame_start.
- line_req during busy: overrun pulses and the original line completes. pixel_clk_rstn asserted mid-READ: outputs 0 immediately, no line_done, front_sel=0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer scan-out arbiter.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN
    } fb_state_t;

    localparam int FB_H_RES  = 640;
    localparam int FB_V_RES  = 480;
    localparam int FB_PIX_W  = 12;
    localparam int FB_ADDR_W = 19;
    localparam int FB_BURST  = 16;

endpackage

// File: rtl/fb_scanout_arbiter_if.sv
// Bundle of the line-prefetch, renderer-write, swap-control and RAM signals.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface fb_scanout_arbiter_if #(
    parameter int PIX_W  = fb_pkg::FB_PIX_W,
    parameter int ADDR_W = fb_pkg::FB_ADDR_W
);

    logic              line_req;
    logic [9:0]        line_y;
    logic              line_busy;
    logic              line_done;
    logic              overrun;
    logic              lb_wr_en;
    logic [9:0]        lb_wr_addr;
    logic [PIX_W-1:0]  lb_wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [9:0]        wr_x;
    logic [9:0]        wr_y;
    logic [PIX_W-1:0]  wr_data;
    logic              swap_req;
    logic              frame_start;
    logic              swap_pending;
    logic              front_sel;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;

    modport slave (
        input  line_req, line_y, wr_valid, wr_x, wr_y, wr_data,
               swap_req, frame_start, mem_rdata,
        output line_busy, line_done, overrun, lb_wr_en, lb_wr_addr, lb_wr_data,
               wr_ready, swap_pending, front_sel, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output line_req, line_y, wr_valid, wr_x, wr_y, wr_data,
               swap_req, frame_start, mem_rdata,
        input  line_busy, line_done, overrun, lb_wr_en, lb_wr_addr, lb_wr_data,
               wr_ready, swap_pending, front_sel, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_swap_ctrl.sv
// Front/back bank selection: a swap request is remembered and only takes
// effect at the next frame start, so scan-out never changes bank mid-frame.
module fb_swap_ctrl (
    input  logic pixel_clk,
    input  logic pixel_clk_rstn,
    input  logic i_swap_req,
    input  logic i_frame_start,
    output logic o_swap_pending,
    output logic o_front_sel
);

    logic r_swap_pending;
    logic r_front_sel;

    // Set pending on request (a same-cycle frame start does not consume it), toggle the front bank at a later frame start
    always_ff @(posedge pixel_clk or negedge pixel_clk_rstn) begin
        if (!pixel_clk_rstn) begin
            r_swap_pending <= 1'b0;
            r_front_sel    <= 1'b0;
        end else if (i_swap_req) begin
            r_swap_pending <= 1'b1;
        end else if (i_frame_start && r_swap_pending) begin
            r_front_sel    <= ~r_front_sel;
            r_swap_pending <= 1'b0;
        end
    end

    assign o_swap_pending = r_swap_pending;
    assign o_front_sel    = r_front_sel;

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Single-port framebuffer arbiter: copies one requested line from the front
// bank into the display line buffer while interleaving fixed renderer write
// slots, and routes renderer pixel writes to the back bank.
module fb_scanout_arbiter
    import fb_pkg::*;
#(
    parameter int H_RES  = FB_H_RES,
    parameter int V_RES  = FB_V_RES,
    parameter int PIX_W  = FB_PIX_W,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int BURST  = FB_BURST
) (
    input  logic                 pixel_clk,
    input  logic                 pixel_clk_rstn,
    fb_scanout_arbiter_if.slave  bus
);

    localparam int                SLOT_W    = $clog2(BURST + 1);
    localparam logic [9:0]        LP_H_RES  = 10'(H_RES);
    localparam logic [9:0]        LP_H_LAST = 10'(H_RES - 1);
    localparam logic [9:0]        LP_V_RES  = 10'(V_RES);
    localparam logic [SLOT_W-1:0] LP_BURST  = SLOT_W'(BURST);
    localparam logic [ADDR_W-1:0] LP_H_MUL  = ADDR_W'(H_RES);

    fb_state_t         r_state;
    fb_state_t         w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic              r_bank;
    logic [9:0]        r_x;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic              r_lb_wr_en;
    logic [9:0]        r_lb_wr_addr;

    logic              w_swap_pending;
    logic              w_front_sel;
    logic              w_line_accept;
    logic              w_slot;
    logic              w_read_issue;
    logic              w_wr_ready;
    logic              w_wr_fire;
    logic              w_wr_in_range;
    logic [ADDR_W-1:0] w_wr_lin;
    logic [ADDR_W-1:0] w_rd_lin;
    logic [PIX_W-1:0]  w_wr_data;

    fb_swap_ctrl u_swap_ctrl (
        .pixel_clk      (pixel_clk),
        .pixel_clk_rstn (pixel_clk_rstn),
        .i_swap_req     (bus.swap_req),
        .i_frame_start  (bus.frame_start),
        .o_swap_pending (w_swap_pending),
        .o_front_sel    (w_front_sel)
    );

    assign w_line_accept = (r_state == IDLE) && bus.line_req && (bus.line_y < LP_V_RES);
    assign w_slot        = (r_state == READ) && (r_slot_cnt == LP_BURST) && (r_x < LP_H_RES);
    assign w_read_issue  = (r_state == READ) && !w_slot;
    assign w_wr_in_range = (bus.wr_x < LP_H_RES) && (bus.wr_y < LP_V_RES);
    assign w_wr_lin      = ADDR_W'(bus.wr_y) * LP_H_MUL + ADDR_W'(bus.wr_x);
    assign w_rd_lin      = r_base + ADDR_W'(r_x);
    assign w_wr_data     = bus.wr_data;

    // State register
    always_ff @(posedge pixel_clk or negedge pixel_clk_rstn) begin
        if (!pixel_clk_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and renderer ready: writes are only offered while idle or in a reserved slot, and never with a swap pending
    always_comb begin
        w_next_state = r_state;
        w_wr_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_wr_ready = !w_swap_pending;
                if (w_line_accept) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_next_state = READ;
            end
            READ: begin
                if (w_slot) begin
                    w_wr_ready = !w_swap_pending;
                end else if (r_x == LP_H_LAST) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Ready is held low while reset is asserted so the whole output set reads zero during reset
    assign w_wr_fire = bus.wr_valid && w_wr_ready && pixel_clk_rstn;

    // Line-fetch datapath: latch the line base on accept, the bank at LOAD, then walk x and the slot counter
    always_ff @(posedge pixel_clk or negedge pixel_clk_rstn) begin
        if (!pixel_clk_rstn) begin
            r_base       <= '0;
            r_bank       <= 1'b0;
            r_x          <= '0;
            r_slot_cnt   <= '0;
            r_lb_wr_en   <= 1'b0;
            r_lb_wr_addr <= '0;
        end else begin
            r_lb_wr_en <= w_read_issue;
            if (w_read_issue) begin
                r_lb_wr_addr <= r_x;
            end
            case (r_state)
                IDLE: begin
                    if (w_line_accept) begin
                        r_base <= ADDR_W'(bus.line_y) * LP_H_MUL;
                    end
                end
                LOAD: begin
                    r_bank     <= w_front_sel;
                    r_x        <= '0;
                    r_slot_cnt <= '0;
                end
                READ: begin
                    if (w_slot) begin
                        r_slot_cnt <= '0;
                    end else begin
                        r_x        <= r_x + 10'd1;
                        r_slot_cnt <= r_slot_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // RAM port mux: a line read has the port except in slot cycles, where an in-range renderer write goes to the back bank
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (w_read_issue) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = {r_bank, w_rd_lin};
        end else if (w_wr_fire && w_wr_in_range) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {~w_front_sel, w_wr_lin};
            bus.mem_wdata = w_wr_data;
        end
    end

    assign bus.wr_ready     = w_wr_ready && pixel_clk_rstn;
    assign bus.line_busy    = (r_state != IDLE);
    assign bus.line_done    = (r_state == DRAIN);
    assign bus.overrun      = bus.line_req && (r_state != IDLE);
    assign bus.lb_wr_en     = r_lb_wr_en;
    assign bus.lb_wr_addr   = r_lb_wr_addr;
    assign bus.lb_wr_data   = bus.mem_rdata;
    assign bus.swap_pending = w_swap_pending;
    assign bus.front_sel    = w_front_sel;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Self-checking bench for fb_scanout_arbiter: a cycle-level behavioural model
// of line timing, slot placement, swaps and memory contents is compared with
// the DUT on every negative clock edge, plus directed literal checks.
module tb_fb_scanout_arbiter;

    localparam int H        = 640;
    localparam int V        = 480;
    localparam int LINE_CYC = 681;
    localparam int BANK_BIT = 1 << 19;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    fb_scanout_arbiter_if bus ();

    fb_scanout_arbiter dut (
        .pixel_clk      (clk),
        .pixel_clk_rstn (rstn),
        .bus            (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int doneCount  = 0;
    int doneCyc    = 0;
    int wrAccepts  = 0;
    int pendCycles = 0;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] initVal(input int a);
        return 12'((a * 29) ^ (a >> 4) ^ 32'h5A3);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // RAM model driving mem_rdata one cycle after a read
    logic [11:0] ram [int];
    logic [11:0] ramRd = 12'd0;
    int          ramA;
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            ramA = int'(bus.mem_addr);
            if (bus.mem_we) ram[ramA] = bus.mem_wdata;
            else            ramRd <= ram.exists(ramA) ? ram[ramA] : initVal(ramA);
        end
    end
    assign bus.mem_rdata = ramRd;

    // Behavioural model state
    bit          mBusy;
    int          mR, mBase, mBank, mFront, mPending;
    bit          mPrevRead;
    int          mPrevX;
    int          mPrevData;
    logic [11:0] mMem [int];
    int          k, eX, eRdAddr, eWrAddr;
    bit          eRead, eSlot, eReady, eWrite;

    function automatic int memVal(input int a);
        return mMem.exists(a) ? int'(mMem[a]) : int'(initVal(a));
    endfunction

    // Compare process: check this cycle's outputs against the model, then advance the model
    always @(negedge clk) begin
        if (!rstn) begin
            checkOutput("rst_line_busy", bus.line_busy, 0);
            checkOutput("rst_line_done", bus.line_done, 0);
            checkOutput("rst_overrun", bus.overrun, 0);
            checkOutput("rst_lb_wr_en", bus.lb_wr_en, 0);
            checkOutput("rst_wr_ready", bus.wr_ready, 0);
            checkOutput("rst_mem_en", bus.mem_en, 0);
            checkOutput("rst_front_sel", bus.front_sel, 0);
            checkOutput("rst_swap_pending", bus.swap_pending, 0);
            mBusy = 0; mR = 0; mBase = 0; mBank = 0; mFront = 0; mPending = 0;
            mPrevRead = 0; mPrevX = 0; mPrevData = 0;
        end else begin
            eRead = 0; eSlot = 0; eX = 0; eRdAddr = 0;
            if (mBusy && mR >= 2 && mR <= LINE_CYC - 1) begin
                k     = mR - 2;
                eSlot = (k % 17) == 16;
                eRead = !eSlot;
                eX    = k - k / 17;
                eRdAddr = mBank * BANK_BIT + mBase + eX;
            end
            eReady  = (!mBusy || eSlot) && !mPending;
            eWrite  = eReady && bus.wr_valid && (int'(bus.wr_x) < H) && (int'(bus.wr_y) < V);
            eWrAddr = (1 - mFront) * BANK_BIT + int'(bus.wr_y) * H + int'(bus.wr_x);

            checkOutput("line_busy", bus.line_busy, mBusy);
            checkOutput("line_done", bus.line_done, mBusy && mR == LINE_CYC);
            checkOutput("overrun", bus.overrun, bus.line_req && mBusy);
            checkOutput("wr_ready", bus.wr_ready, eReady);
            checkOutput("swap_pending", bus.swap_pending, mPending);
            checkOutput("front_sel", bus.front_sel, mFront);
            checkOutput("mem_en", bus.mem_en, eRead || eWrite);
            if (eRead) begin
                checkOutput("read_we", bus.mem_we, 0);
                checkOutput("read_addr", bus.mem_addr, eRdAddr);
            end
            if (eWrite) begin
                checkOutput("write_we", bus.mem_we, 1);
                checkOutput("write_addr", bus.mem_addr, eWrAddr);
                checkOutput("write_data", bus.mem_wdata, bus.wr_data);
            end
            checkOutput("lb_wr_en", bus.lb_wr_en, mPrevRead);
            if (mPrevRead) begin
                checkOutput("lb_wr_addr", bus.lb_wr_addr, mPrevX);
                checkOutput("lb_wr_data", bus.lb_wr_data, mPrevData);
            end

            if (bus.line_done === 1'b1) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (bus.wr_valid && bus.wr_ready === 1'b1) wrAccepts++;
            if (bus.swap_pending === 1'b1) pendCycles++;

            mPrevRead = eRead;
            if (eRead) begin
                mPrevX    = eX;
                mPrevData = memVal(eRdAddr);
            end
            if (eWrite) mMem[eWrAddr] = bus.wr_data;
            if (mBusy) begin
                if (mR == 1) mBank = mFront;
                if (mR == LINE_CYC) mBusy = 0;
                else mR++;
            end else if (bus.line_req && int'(bus.line_y) < V) begin
                mBusy = 1;
                mR    = 1;
                mBase = int'(bus.line_y) * H;
            end
            if (bus.swap_req) mPending = 1;
            else if (bus.frame_start && mPending) begin
                mFront   = 1 - mFront;
                mPending = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randWrite();
        bus.wr_x    = 10'($urandom_range(0, H - 1));
        bus.wr_y    = 10'($urandom_range(0, V - 1));
        bus.wr_data = 12'($urandom);
    endtask

    // Line 3 fetch with the renderer continuously requesting
    task automatic applyStimulusLine3();
        int reqCyc, doneBefore, acc;
        step();
        bus.line_req = 1'b1; bus.line_y = 10'd3; bus.wr_valid = 1'b1; randWrite();
        reqCyc = cyc; doneBefore = doneCount;
        for (int n = 1; n <= 700 && doneCount == doneBefore; n++) begin
            step();
            randWrite();
            if (n == 1) begin
                bus.line_req = 1'b0; wrAccepts = 0; #1;
                checkOutput("load_wr_ready", bus.wr_ready, 0);
                checkOutput("load_line_busy", bus.line_busy, 1);
            end
            if (n == 2) begin
                #1;
                checkOutput("first_read_addr", bus.mem_addr, 1920);
                checkOutput("first_read_we", bus.mem_we, 0);
            end
            if (n == 3) begin
                #1;
                checkOutput("first_lb_en", bus.lb_wr_en, 1);
                checkOutput("first_lb_addr", bus.lb_wr_addr, 0);
                checkOutput("first_lb_data", bus.lb_wr_data, initVal(1920));
            end
            if (n == 18) begin
                #1;
                checkOutput("slot_wr_ready", bus.wr_ready, 1);
                checkOutput("slot_we", bus.mem_we, 1);
                checkOutput("slot_bank", bus.mem_addr >> 19, 1);
            end
        end
        acc = wrAccepts;
        bus.wr_valid = 1'b0;
        checkOutput("line3_done_seen", doneCount - doneBefore, 1);
        checkOutput("line3_done_cycle", doneCyc - reqCyc, LINE_CYC);
        checkOutput("line3_slot_writes", acc, 39);
    endtask

    // Directed idle writes, in and out of range
    task automatic applyStimulusIdleWrite();
        step();
        bus.wr_valid = 1'b1; bus.wr_x = 10'd5; bus.wr_y = 10'd2; bus.wr_data = 12'hABC; #1;
        checkOutput("idle_wr_ready", bus.wr_ready, 1);
        checkOutput("idle_mem_en", bus.mem_en, 1);
        checkOutput("idle_mem_we", bus.mem_we, 1);
        checkOutput("idle_mem_addr", bus.mem_addr, 20'h80505);
        checkOutput("idle_mem_wdata", bus.mem_wdata, 12'hABC);
        step();
        bus.wr_x = 10'd700; #1;
        checkOutput("oob_wr_ready", bus.wr_ready, 1);
        checkOutput("oob_mem_en", bus.mem_en, 0);
        step();
        bus.wr_valid = 1'b0;
    endtask

    // Swap with frame start ten cycles later; renderer stalls meanwhile
    task automatic applyStimulusSwap();
        step();
        bus.swap_req = 1'b1; bus.wr_valid = 1'b1; randWrite(); pendCycles = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            randWrite();
            if (i == 0) begin
                bus.swap_req = 1'b0; #1;
                checkOutput("swap_pending_set", bus.swap_pending, 1);
                checkOutput("swap_stall_ready", bus.wr_ready, 0);
            end
            if (i == 9) bus.frame_start = 1'b1;
        end
        step();
        bus.frame_start = 1'b0; randWrite(); #1;
        checkOutput("swap_pend_cycles", pendCycles, 10);
        checkOutput("swap_front", bus.front_sel, 1);
        checkOutput("swap_cleared", bus.swap_pending, 0);
        checkOutput("swap_new_bank", bus.mem_addr >> 19, 0);
        step();
        bus.wr_valid = 1'b0;
    endtask

    // Line 2 fetch with a second request while busy
    task automatic applyStimulusOverrun();
        int reqCyc, doneBefore;
        step();
        bus.line_req = 1'b1; bus.line_y = 10'd2;
        reqCyc = cyc; doneBefore = doneCount;
        for (int n = 1; n <= 700 && doneCount == doneBefore; n++) begin
            step();
            if (n == 1) bus.line_req = 1'b0;
            if (n == 6) begin
                bus.line_req = 1'b1; bus.line_y = 10'd7; #1;
                checkOutput("overrun_pulse", bus.overrun, 1);
            end
            if (n == 7) begin
                bus.line_req = 1'b0; #1;
                checkOutput("overrun_single", bus.overrun, 0);
            end
        end
        checkOutput("overrun_done_seen", doneCount - doneBefore, 1);
        checkOutput("overrun_done_cycle", doneCyc - reqCyc, LINE_CYC);
        step();
        #1;
        checkOutput("overrun_no_new_line", bus.line_busy, 0);
    endtask

    // Swap request coinciding with frame start waits for the next one
    task automatic applyStimulusSameCycleSwap();
        step();
        bus.swap_req = 1'b1; bus.frame_start = 1'b1;
        step();
        bus.swap_req = 1'b0; bus.frame_start = 1'b0; #1;
        checkOutput("same_cycle_front", bus.front_sel, 1);
        checkOutput("same_cycle_pending", bus.swap_pending, 1);
        repeat (5) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0; #1;
        checkOutput("next_frame_front", bus.front_sel, 0);
        checkOutput("next_frame_pending", bus.swap_pending, 0);
        step();
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        repeat (3) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0; #1;
        checkOutput("reswap_front", bus.front_sel, 1);
    endtask

    // Asynchronous reset in the middle of a line fetch
    task automatic applyStimulusMidReset();
        int doneBefore;
        step();
        bus.line_req = 1'b1; bus.line_y = 10'd100;
        step();
        bus.line_req = 1'b0;
        repeat (100) step();
        doneBefore = doneCount;
        rstn = 1'b0; #1;
        checkOutput("midrst_line_busy", bus.line_busy, 0);
        checkOutput("midrst_mem_en", bus.mem_en, 0);
        checkOutput("midrst_lb_wr_en", bus.lb_wr_en, 0);
        checkOutput("midrst_line_done", bus.line_done, 0);
        checkOutput("midrst_front_sel", bus.front_sel, 0);
        repeat (3) step();
        rstn = 1'b1;
        repeat (700) step();
        checkOutput("midrst_no_done", doneCount - doneBefore, 0);
    endtask

    // Randomised traffic on every input
    task automatic applyStimulusRandom(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            bus.line_req    = ($urandom_range(0, 299) == 0);
            bus.line_y      = 10'($urandom_range(0, 511));
            bus.wr_valid    = 1'($urandom_range(0, 1));
            bus.wr_x        = 10'($urandom_range(0, 700));
            bus.wr_y        = 10'($urandom_range(0, 500));
            bus.wr_data     = 12'($urandom);
            bus.swap_req    = ($urandom_range(0, 199) == 0);
            bus.frame_start = ($urandom_range(0, 149) == 0);
        end
        step();
        bus.line_req = 1'b0; bus.wr_valid = 1'b0; bus.swap_req = 1'b0; bus.frame_start = 1'b0;
    endtask

    // Main sequence
    initial begin
        bus.line_req = 1'b0; bus.line_y = '0; bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0;
        bus.wr_data = '0; bus.swap_req = 1'b0; bus.frame_start = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_line_busy", bus.line_busy, 0);
        checkOutput("reset_front_sel", bus.front_sel, 0);
        checkOutput("reset_wr_ready", bus.wr_ready, 0);
        rstn = 1'b1;
        repeat (2) step();

        $display("[TB] line 3 fetch");
        applyStimulusLine3();
        $display("[TB] idle writes");
        applyStimulusIdleWrite();
        $display("[TB] swap");
        applyStimulusSwap();
        $display("[TB] overrun");
        applyStimulusOverrun();
        $display("[TB] same-cycle swap");
        applyStimulusSameCycleSwap();
        $display("[TB] reset mid-fetch");
        applyStimulusMidReset();
        $display("[TB] random traffic");
        applyStimulusRandom(20000);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
